alarm_keypad: RTL

Code-entry front end for the sensor-alarm controller: collects keypad digits, compares the entered code to a fixed code, and drives the `arm` and `on` levels that the alarm state machine consumes. A correct code while disarmed arms the system after an exit delay. A correct code while armed disarms and silences it. Repeated failures can optionally lock the keypad out.

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_keypad_timer.sv | 28 ++
 rtl/alarm_keypad.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared keypad/alarm types and constants.
// Also imported by the alarm controller.
package alarm_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [15:0] DEFAULT_CODE = 16'h1234;

    typedef enum logic [2:0] {
        KP_IDLE  = 3'd0,
        KP_ENTRY = 3'd1,
        KP_CHECK = 3'd2,
        KP_EXIT  = 3'd3,
        KP_LOCK  = 3'd4
    } kp_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarm_keypad_timer.sv
// Loadable down-counter shared by entry timeout, exit delay and lockout.
// done pulses for the single cycle in which the count reaches its last tick.
module kp_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         start,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (start && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = start && (cnt_q == W'(1));

endmodule

// File: rtl/alarm_keypad.sv
// Keypad code-entry front end driving arm/on for the alarm controller.
// Define ALARM_KEYPAD_LOCKOUT_EN to lock the keypad after MAX_FAILS failures.
module alarm_keypad
    import alarm_pkg::*;
#(
    parameter int CODE_DIGITS = 4,
    parameter logic [CODE_DIGITS*DIGIT_W-1:0] CODE = DEFAULT_CODE,
    parameter int ENTRY_TIMEOUT  = 255,
    parameter int EXIT_DELAY     = 1024,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               enter,
    input  logic               clear,
    output logic               arm,
    output logic               on,
    output logic               code_ok,
    output logic               code_bad,
    output logic               lockout,
    output logic [1:0]         fail_cnt
);

    localparam int EW = CODE_DIGITS * DIGIT_W;
    localparam int CW = $clog2(CODE_DIGITS + 1);
    localparam int TW =
        $clog2(max3(ENTRY_TIMEOUT, EXIT_DELAY, LOCKOUT_CYCLES) + 1);
`ifdef ALARM_KEYPAD_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    kp_state_t     state_q;
    logic [EW-1:0] entry_q;
    logic [CW-1:0] cnt_q;
    logic          bad_q;
    logic          arm_q;
    logic          on_q;
    logic          ok_q;
    logic          badp_q;
    logic [1:0]    fail_q;
`ifdef ALARM_KEYPAD_LOCKOUT_EN
    logic          lockout_q;
`endif

    logic          match;
    logic          digit_bad;
    logic          lock_hit;
    logic [1:0]    fail_inc;
    logic          tmr_load;
    logic          tmr_start;
    logic          tmr_done;
    logic [TW-1:0] tmr_val;

    // A digit above 9 poisons the entry so it can never match.
    assign digit_bad = digit > 4'd9;
    assign match     = (cnt_q == CW'(CODE_DIGITS)) && !bad_q && (entry_q == CODE);
    assign fail_inc  = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
    assign lock_hit  = LOCK_EN && (int'(fail_inc) >= MAX_FAILS);
    assign tmr_start = (state_q == KP_ENTRY) || (state_q == KP_EXIT)
                    || (state_q == KP_LOCK);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            KP_IDLE, KP_ENTRY: begin
                if (!clear && digit_valid) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(ENTRY_TIMEOUT);
                end
            end
            KP_CHECK: begin
                if (match && !arm_q) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(EXIT_DELAY);
                end else if (!match && lock_hit) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(LOCKOUT_CYCLES);
                end
            end
            default: ;
        endcase
    end

    kp_timer #(.W(TW)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (tmr_load),
        .value(tmr_val),
        .start(tmr_start),
        .done (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= KP_IDLE;
            entry_q   <= '0;
            cnt_q     <= '0;
            bad_q     <= 1'b0;
            arm_q     <= 1'b0;
            on_q      <= 1'b0;
            ok_q      <= 1'b0;
            badp_q    <= 1'b0;
            fail_q    <= 2'd0;
`ifdef ALARM_KEYPAD_LOCKOUT_EN
            lockout_q <= 1'b0;
`endif
        end else begin
            ok_q   <= 1'b0;
            badp_q <= 1'b0;
            unique case (state_q)
                KP_IDLE: begin
                    if (!clear && digit_valid) begin
                        entry_q <= EW'(digit);
                        cnt_q   <= CW'(1);
                        bad_q   <= digit_bad;
                        state_q <= KP_ENTRY;
                    end
                end
                KP_ENTRY: begin
                    if (clear) begin
                        state_q <= KP_IDLE;
                    end else if (digit_valid) begin
                        if (cnt_q != CW'(CODE_DIGITS)) begin
                            entry_q <= {entry_q[EW-DIGIT_W-1:0], digit};
                            cnt_q   <= cnt_q + 1'b1;
                            bad_q   <= bad_q | digit_bad;
                        end
                    end else if (enter) begin
                        state_q <= KP_CHECK;
                    end else if (tmr_done) begin
                        state_q <= KP_IDLE;
                    end
                end
                KP_CHECK: begin
                    state_q <= KP_IDLE;
                    if (match) begin
                        ok_q   <= 1'b1;
                        fail_q <= 2'd0;
                        if (arm_q) begin
                            arm_q <= 1'b0;
                            on_q  <= 1'b0;
                        end else begin
                            state_q <= KP_EXIT;
                        end
                    end else begin
                        badp_q <= 1'b1;
                        fail_q <= fail_inc;
                        if (lock_hit) begin
                            state_q <= KP_LOCK;
`ifdef ALARM_KEYPAD_LOCKOUT_EN
                            lockout_q <= 1'b1;
`endif
                        end
                    end
                end
                KP_EXIT: begin
                    if (clear) begin
                        state_q <= KP_IDLE;
                    end else if (tmr_done) begin
                        arm_q   <= 1'b1;
                        on_q    <= 1'b1;
                        state_q <= KP_IDLE;
                    end
                end
                KP_LOCK: begin
                    if (tmr_done) begin
                        fail_q  <= 2'd0;
                        state_q <= KP_IDLE;
`ifdef ALARM_KEYPAD_LOCKOUT_EN
                        lockout_q <= 1'b0;
`endif
                    end
                end
                default: state_q <= KP_IDLE;
            endcase
        end
    end

    assign arm      = arm_q;
    assign on       = on_q;
    assign code_ok  = ok_q;
    assign code_bad = badp_q;
    assign fail_cnt = fail_q;
`ifdef ALARM_KEYPAD_LOCKOUT_EN
    assign lockout  = lockout_q;
`else
    assign lockout  = 1'b0;
`endif

endmodule
